// File: rtl/fdeq_pkg.sv
// Shared constants, state encoding and coefficient record for the FDEQ coefficient scheduler.
package fdeq_pkg;
  localparam int unsigned NFFT       = 32;
  localparam int unsigned W          = 16;
  localparam int unsigned FRAC       = 14;
  localparam int unsigned K_W        = $clog2(NFFT);
  localparam int unsigned REC_W      = 4 * W;
  localparam int unsigned ONE_Q      = 1 << FRAC;
  localparam int unsigned INIT_W0_RE = ONE_Q;
  localparam int unsigned INIT_W1_RE = 0;

  typedef enum logic [1:0] {
    ST_INIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_COPY = 2'd2
  } state_t;

  typedef struct packed {
    logic [W-1:0] w0_re;
    logic [W-1:0] w0_im;
    logic [W-1:0] w1_re;
    logic [W-1:0] w1_im;
  } coef_t;

  function automatic coef_t init_coef();
    coef_t c;
    c.w0_re = W'(INIT_W0_RE);
    c.w0_im = '0;
    c.w1_re = W'(INIT_W1_RE);
    c.w1_im = '0;
    return c;
  endfunction
endpackage

// File: rtl/fdeq_coef_bank.sv
// One coefficient bank: NFFT records, a synchronous write port and two
// combinational read ports (datapath lookup and bank-to-bank copy).
module fdeq_coef_bank
  import fdeq_pkg::*;
(
  input  logic             clk,
  input  logic             we,
  input  logic [K_W-1:0]   wr_addr,
  input  logic [REC_W-1:0] wr_data,
  input  logic [K_W-1:0]   dp_addr,
  output logic [REC_W-1:0] dp_data,
  input  logic [K_W-1:0]   cp_addr,
  output logic [REC_W-1:0] cp_data
);
  logic [REC_W-1:0] mem [NFFT];

  always_ff @(posedge clk) begin
    if (we) mem[wr_addr] <= wr_data;
  end

  assign dp_data = mem[dp_addr];
  assign cp_data = mem[cp_addr];
endmodule

// File: rtl/fdeq_coef_sched.sv
// Tags FFT bins with k and attaches active-bank coefficients; swaps the
// LMS shadow bank in only at block boundaries, then re-syncs the shadow.
module fdeq_coef_sched
  import fdeq_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  input  logic           i_valid,
  input  logic [W-1:0]   i_X_re,
  input  logic [W-1:0]   i_X_im,
  output logic           o_in_ready,
  output logic           o_drop,
  output logic           o_valid,
  output logic [W-1:0]   o_X_re,
  output logic [W-1:0]   o_X_im,
  output logic [W-1:0]   o_W0_re,
  output logic [W-1:0]   o_W0_im,
  output logic [W-1:0]   o_W1_re,
  output logic [W-1:0]   o_W1_im,
  output logic [K_W-1:0] o_k_idx,
  input  logic           i_upd_valid,
  input  logic [K_W-1:0] i_upd_k,
  input  logic [W-1:0]   i_upd_W0_re,
  input  logic [W-1:0]   i_upd_W0_im,
  input  logic [W-1:0]   i_upd_W1_re,
  input  logic [W-1:0]   i_upd_W1_im,
  output logic           o_upd_ready,
  input  logic           i_commit,
  output logic           o_commit_ack,
  output logic           o_bank
);
  state_t           state;
  logic [K_W-1:0]   k;
  logic [K_W-1:0]   cnt;
  logic             pending;
  logic             accept;
  logic             upd_we;
  logic             swap;
  logic             last_cnt;
  logic             we0;
  logic             we1;
  logic [K_W-1:0]   wr_addr;
  logic [REC_W-1:0] wr_data;
  logic [REC_W-1:0] dp0;
  logic [REC_W-1:0] dp1;
  logic [REC_W-1:0] cp0;
  logic [REC_W-1:0] cp1;
  coef_t            act;
  coef_t            cp_src;

  assign accept   = i_valid & o_in_ready;
  assign upd_we   = i_upd_valid & o_upd_ready;
  assign last_cnt = (cnt == K_W'(NFFT - 1));
  // Block boundary: last bin of the block taken now, or idle sitting at bin 0.
  assign swap     = (state == ST_RUN) & pending &
                    (accept ? (k == K_W'(NFFT - 1)) : (k == '0));
  assign act      = o_bank ? dp1 : dp0;
  assign cp_src   = o_bank ? cp1 : cp0;

  // Bank write steering: both banks in INIT, only the shadow (~o_bank) otherwise.
  always_comb begin
    we0     = 1'b0;
    we1     = 1'b0;
    wr_addr = cnt;
    wr_data = init_coef();
    case (state)
      ST_INIT: begin
        we0 = 1'b1;
        we1 = 1'b1;
      end
      ST_RUN: begin
        wr_addr = i_upd_k;
        wr_data = {i_upd_W0_re, i_upd_W0_im, i_upd_W1_re, i_upd_W1_im};
        we0     = upd_we & o_bank;
        we1     = upd_we & ~o_bank;
      end
      ST_COPY: begin
        wr_data = cp_src;
        we0     = o_bank;
        we1     = ~o_bank;
      end
      default: ;
    endcase
  end

  fdeq_coef_bank u_bank0 (
    .clk     (clk),
    .we      (we0),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .dp_addr (k),
    .dp_data (dp0),
    .cp_addr (cnt),
    .cp_data (cp0)
  );

  fdeq_coef_bank u_bank1 (
    .clk     (clk),
    .we      (we1),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .dp_addr (k),
    .dp_data (dp1),
    .cp_addr (cnt),
    .cp_data (cp1)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_INIT;
      k            <= '0;
      cnt          <= '0;
      pending      <= 1'b0;
      o_in_ready   <= 1'b0;
      o_upd_ready  <= 1'b0;
      o_drop       <= 1'b0;
      o_valid      <= 1'b0;
      o_commit_ack <= 1'b0;
      o_bank       <= 1'b0;
      o_X_re       <= '0;
      o_X_im       <= '0;
      o_W0_re      <= '0;
      o_W0_im      <= '0;
      o_W1_re      <= '0;
      o_W1_im      <= '0;
      o_k_idx      <= '0;
    end else begin
      o_valid      <= accept;
      o_drop       <= i_valid & ~o_in_ready;
      o_commit_ack <= 1'b0;
      if (accept) begin
        o_X_re  <= i_X_re;
        o_X_im  <= i_X_im;
        o_W0_re <= act.w0_re;
        o_W0_im <= act.w0_im;
        o_W1_re <= act.w1_re;
        o_W1_im <= act.w1_im;
        o_k_idx <= k;
        k       <= k + K_W'(1);
      end
      case (state)
        ST_INIT: begin
          cnt <= cnt + K_W'(1);
          if (last_cnt) begin
            state       <= ST_RUN;
            o_in_ready  <= 1'b1;
            o_upd_ready <= 1'b1;
          end
        end
        ST_RUN: begin
          if (i_commit && o_upd_ready) begin
            pending     <= 1'b1;
            o_upd_ready <= 1'b0;
          end
          if (swap) begin
            o_bank       <= ~o_bank;
            pending      <= 1'b0;
            o_commit_ack <= 1'b1;
            cnt          <= '0;
            state        <= ST_COPY;
          end
        end
        ST_COPY: begin
          cnt <= cnt + K_W'(1);
          if (last_cnt) begin
            state       <= ST_RUN;
            o_upd_ready <= 1'b1;
          end
        end
        default: state <= ST_INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_fdeq_coef_sched.sv
// Self-checking bench for fdeq_coef_sched: vector table, directed corner sequences
// and a randomized run against a bank-level reference model.
module tb_fdeq_coef_sched;
  import fdeq_pkg::*;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           i_valid = 1'b0;
  logic [W-1:0]   i_X_re = '0, i_X_im = '0;
  logic           i_upd_valid = 1'b0;
  logic [K_W-1:0] i_upd_k = '0;
  logic [W-1:0]   i_upd_W0_re = '0, i_upd_W0_im = '0, i_upd_W1_re = '0, i_upd_W1_im = '0;
  logic           i_commit = 1'b0;
  logic           o_in_ready, o_drop, o_valid, o_upd_ready, o_commit_ack, o_bank;
  logic [W-1:0]   o_X_re, o_X_im, o_W0_re, o_W0_im, o_W1_re, o_W1_im;
  logic [K_W-1:0] o_k_idx;

  always #5 clk = ~clk;

  fdeq_coef_sched dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_X_re(i_X_re), .i_X_im(i_X_im),
    .o_in_ready(o_in_ready), .o_drop(o_drop), .o_valid(o_valid),
    .o_X_re(o_X_re), .o_X_im(o_X_im),
    .o_W0_re(o_W0_re), .o_W0_im(o_W0_im), .o_W1_re(o_W1_re), .o_W1_im(o_W1_im),
    .o_k_idx(o_k_idx),
    .i_upd_valid(i_upd_valid), .i_upd_k(i_upd_k),
    .i_upd_W0_re(i_upd_W0_re), .i_upd_W0_im(i_upd_W0_im),
    .i_upd_W1_re(i_upd_W1_re), .i_upd_W1_im(i_upd_W1_im),
    .o_upd_ready(o_upd_ready), .i_commit(i_commit),
    .o_commit_ack(o_commit_ack), .o_bank(o_bank)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: two coefficient tables, block phase and handshake flags.
  int m_w [2][NFFT][4];
  int m_phase = 0;   // 0 init, 1 run, 2 copy
  int m_cnt = 0, m_k = 0, m_bank = 0;
  bit m_pend = 0, m_inr = 0, m_updr = 0;
  bit e_valid = 0, e_drop = 0, e_ack = 0;
  int e_k = 0, e_xr = 0, e_xi = 0;
  int e_w [4] = '{0, 0, 0, 0};

  function automatic void model_step();
    bit acc, sw;
    if (rst) begin
      for (int b = 0; b < 2; b++)
        for (int i = 0; i < NFFT; i++) m_w[b][i] = '{16384, 0, 0, 0};
      m_phase = 0; m_cnt = 0; m_k = 0; m_bank = 0;
      m_pend = 0; m_inr = 0; m_updr = 0;
      e_valid = 0; e_drop = 0; e_ack = 0; e_k = 0; e_xr = 0; e_xi = 0;
      e_w = '{0, 0, 0, 0};
      return;
    end
    acc = i_valid && m_inr;
    sw = (m_phase == 1) && m_pend && (acc ? (m_k == NFFT - 1) : (m_k == 0));
    e_valid = acc;
    e_drop = i_valid && !m_inr;
    e_ack = 0;
    if (acc) begin
      e_xr = int'(i_X_re); e_xi = int'(i_X_im); e_k = m_k;
      for (int j = 0; j < 4; j++) e_w[j] = m_w[m_bank][m_k][j];
      m_k = (m_k + 1) % NFFT;
    end
    case (m_phase)
      0: begin
        m_cnt++;
        if (m_cnt == NFFT) begin m_phase = 1; m_inr = 1; m_updr = 1; end
      end
      1: begin
        if (m_updr && i_upd_valid)
          m_w[1 - m_bank][i_upd_k] = '{int'(i_upd_W0_re), int'(i_upd_W0_im),
                                       int'(i_upd_W1_re), int'(i_upd_W1_im)};
        if (i_commit && m_updr) begin m_pend = 1; m_updr = 0; end
        if (sw) begin
          m_bank = 1 - m_bank; m_pend = 0; e_ack = 1; m_phase = 2; m_cnt = 0;
          // Shadow is neither read nor writable until the copy completes.
          for (int i = 0; i < NFFT; i++) m_w[1 - m_bank][i] = m_w[m_bank][i];
        end
      end
      default: begin
        m_cnt++;
        if (m_cnt == NFFT) begin m_phase = 1; m_updr = 1; end
      end
    endcase
  endfunction

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic [106:0] got, exp;
    model_step();
    @(posedge clk);
    #1;
    got = {o_valid, o_drop, o_commit_ack, o_bank, o_in_ready, o_upd_ready, o_k_idx,
           o_X_re, o_X_im, o_W0_re, o_W0_im, o_W1_re, o_W1_im};
    exp = {e_valid, e_drop, e_ack, 1'(m_bank), m_inr, m_updr, K_W'(e_k),
           W'(e_xr), W'(e_xi), W'(e_w[0]), W'(e_w[1]), W'(e_w[2]), W'(e_w[3])};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL model_cmp: got %h expected %h (t=%0t)", got, exp, $time);
    end
  endtask

  task automatic set_upd(input bit v, input int kk, input int w0r, input int w1r);
    i_upd_valid = v; i_upd_k = K_W'(kk);
    i_upd_W0_re = W'(w0r); i_upd_W0_im = '0; i_upd_W1_re = W'(w1r); i_upd_W1_im = '0;
  endtask

  task automatic wait_upd_ready(input string name);
    int n = 0;
    while (!o_upd_ready && n < 64) begin tick(); n++; end
    chk(name, int'(o_upd_ready), 1);
  endtask

  typedef struct {
    bit rst; bit iv; int xr;
    bit ev; bit einr; bit eupdr; int ek; int exr; int ew0; int ew1;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(bit r, bit iv, int xr, bit ev, bit inr, bit updr,
                              int ek, int exr, int ew0, int ew1);
    vec_t v;
    v.rst = r; v.iv = iv; v.xr = xr; v.ev = ev; v.einr = inr; v.eupdr = updr;
    v.ek = ek; v.exr = exr; v.ew0 = ew0; v.ew1 = ew1;
    return v;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int z, n, nval, ndrop;
    // Power-up: 2 reset cycles, 32 INIT cycles with ready low, then one block of X_re=1000.
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < NFFT - 1; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    for (int i = 0; i < NFFT; i++) tbl.push_back(mk(0, 1, 1000, 1, 1, 1, i, 1000, 16384, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));

    foreach (tbl[r]) begin
      rst = tbl[r].rst; i_valid = tbl[r].iv; i_X_re = W'(tbl[r].xr); i_X_im = '0;
      tick();
      chk("tbl_valid", int'(o_valid), int'(tbl[r].ev));
      chk("tbl_in_ready", int'(o_in_ready), int'(tbl[r].einr));
      chk("tbl_upd_ready", int'(o_upd_ready), int'(tbl[r].eupdr));
      if (tbl[r].ev) begin
        chk("tbl_k", int'(o_k_idx), tbl[r].ek);
        chk("tbl_x_re", int'(o_X_re), tbl[r].exr);
        chk("tbl_w0_re", int'(o_W0_re), tbl[r].ew0);
        chk("tbl_w1_re", int'(o_W1_re), tbl[r].ew1);
      end
    end

    // Fill the shadow with W1_re=1.0; without commit the active bank is unchanged.
    for (int i = 0; i < NFFT; i++) begin set_upd(1, i, 16384, 16384); tick(); end
    set_upd(0, 0, 0, 0);
    for (int i = 0; i < NFFT; i++) begin
      i_valid = 1; i_X_re = W'(i); tick();
      chk("t2_nocommit_w1", int'(o_W1_re), 0);
    end
    // Commit mid-block at k=10: rest of block stays old, swap lands with bin 31.
    for (int i = 0; i < NFFT; i++) begin
      i_commit = (i == 10); tick();
      chk("t2_tail_w1", int'(o_W1_re), 0);
      if (i == NFFT - 1) begin
        chk("t2_ack", int'(o_commit_ack), 1);
        chk("t2_bank", int'(o_bank), 1);
      end else chk("t2_ack_early", int'(o_commit_ack), 0);
    end
    i_commit = 0;
    // Next block runs during COPY with the new bank; a write during COPY is ignored.
    z = 0;
    for (int i = 0; i < NFFT; i++) begin
      set_upd(i == 4, 5, 0, 0); tick();
      chk("t3_new_w1", int'(o_W1_re), 16384);
      chk("t3_k", int'(o_k_idx), i);
      if (!o_upd_ready) z++;
    end
    set_upd(0, 0, 0, 0);
    chk("t3_upd_ready_low", z, NFFT - 1);
    chk("t3_upd_ready_back", int'(o_upd_ready), 1);
    // Idle at k=0: write k=5 and commit together, swap follows on the next edge.
    i_valid = 0; set_upd(1, 5, 8192, 16384); i_commit = 1; tick();
    set_upd(0, 0, 0, 0); i_commit = 0;
    chk("t3_upd_ready_pend", int'(o_upd_ready), 0);
    tick();
    chk("t3_ack", int'(o_commit_ack), 1);
    chk("t3_bank", int'(o_bank), 0);
    chk("t3_no_valid", int'(o_valid), 0);
    for (int i = 0; i < NFFT; i++) begin
      i_valid = 1; i_X_re = W'(100 + i); tick();
      chk("t3_w0", int'(o_W0_re), (i == 5) ? 8192 : 16384);
      chk("t3_copied_w1", int'(o_W1_re), 16384);
    end
    i_valid = 0;
    wait_upd_ready("t3_copy_done");

    // Idle commit at k=0: ack within two cycles, no output bins.
    i_commit = 1; tick(); i_commit = 0;
    n = 0; nval = int'(o_valid);
    while (!o_commit_ack && n < 4) begin tick(); n++; nval += int'(o_valid); end
    chk("t4_ack_latency", n, 1);
    chk("t4_no_valid", nval, 0);
    chk("t4_bank", int'(o_bank), 1);
    wait_upd_ready("t4_copy_done");

    // Reset with a commit pending at k=17.
    for (int i = 0; i < 17; i++) begin
      i_valid = 1; i_X_re = W'(i); i_commit = (i == 3); tick();
    end
    i_commit = 0;
    chk("t6_pending", int'(o_upd_ready), 0);
    rst = 1; tick(); rst = 0; i_valid = 0;
    chk("t6_rst_outs", int'(|{o_valid, o_drop, o_commit_ack, o_bank, o_in_ready, o_upd_ready,
        o_k_idx, o_X_re, o_X_im, o_W0_re, o_W0_im, o_W1_re, o_W1_im}), 0);
    repeat (NFFT) tick();
    chk("t6_ready_after_init", int'(o_in_ready), 1);
    for (int i = 0; i < NFFT; i++) begin
      i_valid = 1; i_X_re = 7; tick();
      chk("t6_k", int'(o_k_idx), i);
      chk("t6_w0", int'(o_W0_re), 16384);
      chk("t6_w1", int'(o_W1_re), 0);
    end

    // Bins offered during INIT are dropped, first bin after INIT is k=0.
    i_valid = 0; rst = 1; tick(); rst = 0;
    i_valid = 1; i_X_re = 500; ndrop = 0; nval = 0;
    repeat (NFFT) begin tick(); ndrop += int'(o_drop); nval += int'(o_valid); end
    chk("t5_drops", ndrop, NFFT);
    chk("t5_no_valid", nval, 0);
    tick();
    chk("t5_first_valid", int'(o_valid), 1);
    chk("t5_first_k", int'(o_k_idx), 0);
    chk("t5_no_drop", int'(o_drop), 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) < 3);
      i_valid = ($urandom_range(0, 99) < 70);
      i_X_re = W'($urandom); i_X_im = W'($urandom);
      i_upd_valid = ($urandom_range(0, 99) < 30);
      i_upd_k = K_W'($urandom);
      i_upd_W0_re = W'($urandom); i_upd_W0_im = W'($urandom);
      i_upd_W1_re = W'($urandom); i_upd_W1_im = W'($urandom);
      i_commit = ($urandom_range(0, 99) < 4);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fdeq_coef_sched.md
Name: fdeq_coef_sched

Overview:
Coefficient scheduler and block sequencer in front of the frequency-domain equalizer history stage. It tags each incoming FFT bin with its index k and outputs the bin with that bin's W0/W1 coefficients from an active bank. The LMS update engine writes a shadow bank, and a commit request swaps the banks only at a block boundary, so one block never mixes old and new coefficients. After a swap, the active bank is copied into the new shadow, one entry per cycle.

Parameters:
NFFT, 32, bins per block (power of 2)
W, 16, sample/coefficient width, signed
FRAC, 14, fractional bits (Q2.14)
INIT_W0_RE, 16384, reset value of W0_re for all bins (1.0)
INIT_W1_RE, 0, reset value of W1_re for all bins; imag parts reset to 0

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_valid  in  1  FFT bin valid
i_X_re, i_X_im  in  W each  FFT bin
o_in_ready  out  1  bins accepted
o_drop  out  1  one-cycle pulse: bin offered while o_in_ready=0
o_valid  out  1  output bin valid
o_X_re, o_X_im  out  W each  registered bin
o_W0_re, o_W0_im, o_W1_re, o_W1_im  out  W each  active coefficients for o_k_idx
o_k_idx  out  clog2(NFFT)  bin index
i_upd_valid  in  1  shadow write strobe
i_upd_k  in  clog2(NFFT)  shadow write index
i_upd_W0_re, i_upd_W0_im, i_upd_W1_re, i_upd_W1_im  in  W each  shadow write data
o_upd_ready  out  1  shadow writable
i_commit  in  1  request bank swap
o_commit_ack  out  1  one-cycle pulse one cycle after the swap
o_bank  out  1  active bank index

Behaviour:
- Reset: all outputs 0, including o_in_ready, o_upd_ready and o_bank. k=0, pending commit cleared, state INIT.
- States: INIT -> RUN -> (commit swap) -> COPY -> RUN.
- INIT: lasts NFFT cycles after rst deasserts. Entry i of both banks is written with the INIT values. o_in_ready=0 and o_upd_ready=0. Then go to RUN.
- Datapath (RUN and COPY): a bin is accepted when i_valid & o_in_ready.
  - Latency is 1 cycle: o_valid=1, o_X is the accepted bin, o_k_idx is the current k, and o_W* is active[k].
  - k increments per accepted bin and wraps NFFT-1 -> 0. Gaps in i_valid hold k.
  - o_valid=0 on cycles without an accepted bin; other outputs hold their last values.
- Drop: i_valid while o_in_ready=0 -> o_drop pulses next cycle. Bin discarded, k unchanged, no o_valid.
- Shadow writes: allowed only when o_upd_ready=1 (RUN, no commit pending).
  - i_upd_valid writes shadow[i_upd_k] at the clock edge.
  - Writes while o_upd_ready=0 are ignored.
- Commit:
  - i_commit while o_upd_ready=1 sets pending and drops o_upd_ready the next cycle. An update strobed in the same cycle is still written.
  - i_commit ignored otherwise.
- Swap: evaluated only from the registered pending flag. It occurs at the first edge where either:
  - a bin with k=NFFT-1 is accepted, or
  - k=0 and no bin is accepted.
  On swap: o_bank toggles, pending clears, o_commit_ack pulses next cycle, state goes to COPY. The next accepted bin (k=0) uses the new bank.
- COPY: NFFT cycles, copying new active[c] -> new shadow[c] for c = 0..NFFT-1.
  - Datapath continues unaffected. o_upd_ready=0, i_commit ignored.
  - At the end, return to RUN with o_upd_ready=1.
- Arithmetic: none. Coefficients pass through as stored (Q2.14, no saturation).
- Reset mid-operation: block truncated, pending/COPY abandoned, banks re-initialized through INIT, o_bank=0.

Decomposition:
- Package fdeq_pkg: NFFT, W, FRAC, K_W=clog2(NFFT), ONE_Q=1<<FRAC, state encoding (ST_INIT, ST_RUN, ST_COPY), coefficient record width 4*W.
- Sub-module fdeq_coef_bank, instantiated twice:
  - NFFT x 4W array
  - one synchronous write port
  - two combinational read ports (datapath, copy)
- Scheduler holds the FSM, k counter, pending flag, bank select and output registers.

Test Plan:
1. Reset 2 cycles, then i_valid=0 -> o_in_ready=0 for exactly 32 cycles. Then one block of 32 bins X_re=1000 -> 32 o_valid, 1-cycle latency, o_k 0..31, o_X_re=1000, o_W0_re=16384, o_W1_re=0.
2. Write shadow k=0..31 with W1_re=16384, no commit -> next block still W1_re=0. Then commit at k=10 mid-block -> bins 10..31 keep W1_re=0. Ack pulses after k=31 is accepted, o_bank=1, next block W1_re=16384 at every k.
3. After ack: o_upd_ready=0 for 32 cycles and an i_upd_valid(k=5, W0_re=0) during COPY is ignored. After COPY: write k=5 W0_re=8192 and commit -> next block k=5 gives W0_re=8192, other k give 16384, all k give W1_re=16384 (copy verified).
4. Idle at k=0, commit -> swap and ack within 2 cycles, no o_valid, o_bank toggles.
5. i_valid=1 during INIT with X_re=500 -> o_drop pulse per bin, no o_valid. First bin after INIT gets o_k_idx=0.
6. Commit pending, rst asserted at k=17 -> next cycle all outputs 0 and o_bank=0. After INIT, next block outputs k=0.. with W0_re=16384, W1_re=0.
